// File: rtl/pc_sequencer_if.sv
// ----------------------------------------------------------------------------
// pc_sequencer_if
// Bus between the decode/control side and the program-counter sequencer.
//
// Signals (named from the control side's point of view):
//   stall               - hold the current address this cycle
//   branch_taken        - redirect to a PC-relative target
//   branch_offset[15:0] - signed word offset for branch_taken
//   jump                - redirect to an absolute target
//   jump_target         - absolute jump address
//   link_enable         - with jump, capture the return address
//   halt_req            - stop fetching until reset
//   instruction_address - address presented to instruction_fetch
//   fetch_valid         - instruction_address is a live fetch
//   flush               - one-cycle pulse following any redirect
//   link_address        - saved return address
//   halted              - sequencer is parked in HALT
//
// Modports:
//   master - the control side (drives requests, observes the sequencer)
//   slave  - the sequencer itself
// ----------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  stall;
    logic                  branch_taken;
    logic [15:0]           branch_offset;
    logic                  jump;
    logic [ADDR_WIDTH-1:0] jump_target;
    logic                  link_enable;
    logic                  halt_req;
    logic [ADDR_WIDTH-1:0] instruction_address;
    logic                  fetch_valid;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] link_address;
    logic                  halted;

    modport master (
        output stall, branch_taken, branch_offset, jump, jump_target,
               link_enable, halt_req,
        input  instruction_address, fetch_valid, flush, link_address, halted
    );

    modport slave (
        input  stall, branch_taken, branch_offset, jump, jump_target,
               link_enable, halt_req,
        output instruction_address, fetch_valid, flush, link_address, halted
    );
endinterface

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
// Program-counter stage feeding instruction_fetch. Produces a word-indexed
// instruction address every cycle and handles sequential increment,
// PC-relative branches, absolute jumps with optional link, stall and halt.
// Every output comes straight from a flop; nothing is combinational from
// the inputs.
//
// Ports:
//   clk   - clock, all state changes on the rising edge
//   reset - asynchronous, active-low reset
//   bus   - pc_sequencer_if.slave (requests in, address/status out)
//
// Parameters:
//   ADDR_WIDTH - width of the word address
//   RESET_ADDR - address presented after reset
// ----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic          clk,
    input  logic          reset,
    pc_sequencer_if.slave bus
);

    // The branch sum is formed at least 17 bits wide so the signed 16-bit
    // offset and the carry from +1 are never lost before truncation.
    localparam int SUM_W = (ADDR_WIDTH > 16) ? ADDR_WIDTH + 1 : 17;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } seqState_t;

    seqState_t             r_state;
    seqState_t             w_nextState;

    logic [ADDR_WIDTH-1:0] r_instrAddr;
    logic                  r_fetchValid;
    logic                  r_flush;
    logic [ADDR_WIDTH-1:0] r_linkAddr;
    logic                  r_halted;

    logic [ADDR_WIDTH-1:0] w_nextAddr;
    logic                  w_nextFetchValid;
    logic                  w_nextFlush;
    logic [ADDR_WIDTH-1:0] w_nextLink;
    logic                  w_nextHalted;

    logic [ADDR_WIDTH-1:0] w_seqAddr;
    logic [SUM_W-1:0]      w_branchSum;
    logic [ADDR_WIDTH-1:0] w_branchTarget;
    logic [SUM_W-ADDR_WIDTH-1:0] w_unusedSumHigh;

    // Sequential successor; also the return address for a linked jump.
    assign w_seqAddr = r_instrAddr + ADDR_WIDTH'(1);

    // Branch target wraps modulo 2^ADDR_WIDTH; the upper sum bits are
    // deliberately discarded.
    assign w_branchSum = {{(SUM_W-ADDR_WIDTH){1'b0}}, r_instrAddr}
                       + SUM_W'(1)
                       + {{(SUM_W-16){bus.branch_offset[15]}}, bus.branch_offset};
    assign {w_unusedSumHigh, w_branchTarget} = w_branchSum;

    // Next-state and next-output decode. Redirect priority inside RUN is
    // halt > jump > branch > stall > increment, so a redirect always beats
    // a simultaneous stall and a jump always beats a branch.
    always_comb begin
        w_nextState      = r_state;
        w_nextAddr       = r_instrAddr;
        w_nextFetchValid = r_fetchValid;
        w_nextFlush      = 1'b0;
        w_nextLink       = r_linkAddr;
        w_nextHalted     = r_halted;

        case (r_state)
            BOOT: begin
                w_nextState      = RUN;
                w_nextFetchValid = 1'b1;
            end
            RUN: begin
                if (bus.halt_req) begin
                    w_nextState      = HALT;
                    w_nextFetchValid = 1'b0;
                    w_nextHalted     = 1'b1;
                end else if (bus.jump) begin
                    w_nextAddr  = bus.jump_target;
                    w_nextFlush = 1'b1;
                    if (bus.link_enable) begin
                        w_nextLink = w_seqAddr;
                    end
                end else if (bus.branch_taken) begin
                    w_nextAddr  = w_branchTarget;
                    w_nextFlush = 1'b1;
                end else if (!bus.stall) begin
                    w_nextAddr = w_seqAddr;
                end
            end
            HALT: begin
                w_nextFetchValid = 1'b0;
                w_nextHalted     = 1'b1;
            end
            default: begin
                w_nextState      = BOOT;
                w_nextAddr       = RESET_ADDR;
                w_nextFetchValid = 1'b0;
                w_nextHalted     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset is asynchronous so a mid-cycle
    // reset pulse takes effect without waiting for a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= BOOT;
            r_instrAddr  <= RESET_ADDR;
            r_fetchValid <= 1'b0;
            r_flush      <= 1'b0;
            r_linkAddr   <= '0;
            r_halted     <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_instrAddr  <= w_nextAddr;
            r_fetchValid <= w_nextFetchValid;
            r_flush      <= w_nextFlush;
            r_linkAddr   <= w_nextLink;
            r_halted     <= w_nextHalted;
        end
    end

    assign bus.instruction_address = r_instrAddr;
    assign bus.fetch_valid         = r_fetchValid;
    assign bus.flush               = r_flush;
    assign bus.link_address        = r_linkAddr;
    assign bus.halted              = r_halted;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter stage directly upstream of instruction_fetch. It generates the 8-bit word-indexed instruction_address each cycle. It handles sequential increment, PC-relative branch, absolute jump with optional link, stall and halt. It reports whether the presented address is valid and flags a one-cycle flush on every redirect.

Parameters:
ADDR_WIDTH, 8, width of instruction_address (word index; +1 = next instruction)
RESET_ADDR, 0, address presented after reset

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
stall  input  1  hold current address this cycle
branch_taken  input  1  redirect to PC-relative target
branch_offset  input  16  signed word offset (decoder's constant field)
jump  input  1  redirect to absolute target
jump_target  input  ADDR_WIDTH  absolute jump address
link_enable  input  1  with jump: capture return address
halt_req  input  1  stop fetching until reset
instruction_address  output  ADDR_WIDTH  address to instruction_fetch
fetch_valid  output  1  instruction_address is a live fetch
flush  output  1  one-cycle pulse after any redirect
link_address  output  ADDR_WIDTH  saved return address
halted  output  1  sequencer in HALT

Behaviour:
- Reset (reset=0, asynchronous, any state): instruction_address=RESET_ADDR, fetch_valid=0, flush=0, link_address=0, halted=0, state=BOOT.
- All outputs are registered. No combinational path from any input to any output.
- States:
  - BOOT: first clock after reset release goes to RUN. Sets fetch_valid=1, holds address, ignores all inputs.
  - RUN: normal operation.
  - HALT: terminal. Only reset exits it.
- RUN priority each edge, highest first:
  1. halt_req: go to HALT. Hold address. fetch_valid=0, halted=1, flush=0.
  2. jump: instruction_address <= jump_target. flush=1. If link_enable, link_address <= instruction_address+1 (mod 2^ADDR_WIDTH).
  3. branch_taken: instruction_address <= instruction_address + 1 + sign_extend(branch_offset). Computed in 17+ bits, then truncated to ADDR_WIDTH (mod 2^ADDR_WIDTH). flush=1.
  4. stall: hold address. fetch_valid stays 1. flush=0.
  5. Otherwise: instruction_address <= instruction_address + 1. flush=0.
- flush is high for exactly one cycle per redirect. Back-to-back redirects keep it high on consecutive cycles.
- A redirect overrides a simultaneous stall; the stall is dropped.
- jump and branch_taken together: jump wins, branch ignored.
- link_enable without jump: no effect.
- link_address holds its value until the next linked jump.
- Wrap-around: address (2^ADDR_WIDTH)-1 increments to 0 without error. Branch targets wrap the same way.
- Inputs during BOOT and HALT are ignored, including jump, branch and stall.
- Reset asserted mid-operation (during stall, redirect or HALT) returns immediately to reset values regardless of clk.

Test Plan:
- Reset 0→1, no other inputs: after reset instruction_address=0, fetch_valid=0. Next edge: fetch_valid=1, address 0. Following edges: 1, 2, 3.
- At address 5, branch_taken=1, branch_offset=16'hFFFD (−3) for one cycle: next address 3, flush=1 for that one cycle. Then 4, 5.
- At address 10, jump=1, jump_target=8'h40, link_enable=1: address 0x40, link_address=11, flush=1. Jump with link_enable=0 next: link_address stays 11.
- At address 7, stall=1 for 3 cycles: address stays 7 and fetch_valid=1 throughout. stall=1 together with jump (target 0x20): address 0x20 next, flush=1.
- Run to address 0xFF, no inputs: next address 0x00. At 0xFE, branch_offset=2: target wraps to 0x01.
- halt_req at address 9: halted=1, fetch_valid=0, address held at 9 despite a jump on the next cycle. Pulse reset low mid-cycle: outputs return to reset values asynchronously.
